// File: rtl/mem_pkg.sv
// Shared constants for the four-bank word memory responder: word size, bank count,
// read latency and the address bit positions used to split a byte address.
package mem_pkg;
    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int NUM_BANKS       = 4;
    localparam int RD_LATENCY      = 2;
    localparam int BUSY_CYCLES_DEF = 4;
    localparam int ROW_BITS_DEF    = 13;

    // Byte address layout: [0] byte select (must be 0), [2:1] bank, [3+ROW_BITS-1:3] row.
    localparam int BANK_LSB = 1;
    localparam int BANK_W   = 2;
    localparam int ROW_LSB  = 3;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word array with a registered read row, the one-stage read-valid
// flag, and the down-counter that keeps the bank occupied after each accept.
module mem_bank
    import mem_pkg::*;
#(
    parameter int ROW_BITS    = ROW_BITS_DEF,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic                wr,
    input  logic [ROW_BITS-1:0] row,
    input  word_t               data_in,
    output logic                busy,
    output logic                rd_vld,
    output word_t               rd_word
);
    localparam int              CNT_W    = $clog2(BUSY_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    word_t               mem [2**ROW_BITS];
    logic [CNT_W-1:0]    cnt;
    logic [ROW_BITS-1:0] row_p1;
    logic                vld_p1;

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[row] <= data_in;
        end
    end

    // Stage p1: read row captured at the end of the accept cycle.
    always_ff @(posedge clk) begin
        if (accept && !wr) begin
            row_p1 <= row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            cnt    <= '0;
        end else begin
            vld_p1 <= accept && !wr;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy    = (cnt != '0);
    assign rd_vld  = vld_p1;
    assign rd_word = mem[row_p1];
endmodule

// File: rtl/banked_mem_resp.sv
// Four-bank memory responder: decodes the request address, refuses illegal or
// busy-bank requests combinationally, and registers read data two cycles after accept.
module banked_mem_resp
    import mem_pkg::*;
#(
    parameter int ROW_BITS    = ROW_BITS_DEF,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 rd,
    input  logic                 wr,
    output logic [WORD_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);
    logic                req;
    logic                accept;
    logic [BANK_W-1:0]   bank;
    logic [ROW_BITS-1:0] row;
    logic                bank_vld  [NUM_BANKS];
    word_t               bank_word [NUM_BANKS];
    logic                any_vld;
    word_t               sel_word;

    assign req    = rd | wr;
    assign bank   = addr[BANK_LSB +: BANK_W];
    assign row    = addr[ROW_LSB +: ROW_BITS];
    assign err    = req & (addr[0] | (rd & wr));
    assign stall  = req & ~err & busy[bank];
    assign accept = req & ~err & ~stall;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        mem_bank #(
            .ROW_BITS    (ROW_BITS),
            .BUSY_CYCLES (BUSY_CYCLES)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .accept  (accept && (bank == BANK_W'(i))),
            .wr      (wr),
            .row     (row),
            .data_in (data_in),
            .busy    (busy[i]),
            .rd_vld  (bank_vld[i]),
            .rd_word (bank_word[i])
        );
    end

    // Only one read is accepted per cycle, so at most one bank presents a valid word.
    always_comb begin
        any_vld  = 1'b0;
        sel_word = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_vld[i]) begin
                any_vld  = 1'b1;
                sel_word = bank_word[i];
            end
        end
    end

    // Stage p2: selected word registered onto the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= any_vld;
            if (any_vld) begin
                data_out <= sel_word;
            end
        end
    end
endmodule

// File: tb/tb_banked_mem_resp.sv
// Scoreboard bench for banked_mem_resp: directed requests push expected read data with
// its due cycle; a monitor compares rd_valid/data_out every cycle against the queue head.
module tb_banked_mem_resp;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    banked_mem_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .wr       (wr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One request held for one full cycle; checks err/stall and queues an expected read.
    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic e_err, input logic e_stall,
                         input logic [15:0] e_data, input bit push);
        @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d;
        #1;
        chk("err", err, e_err);
        chk("stall", stall, e_stall);
        if (push && r && !w && !e_err && !e_stall)
            q.push_back('{data: e_data, due: cyc + RD_LATENCY});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
        end
    endtask

    task automatic idle_busy(input int n, input logic [3:0] e_busy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
            #1;
            chk("busy", busy, e_busy);
        end
    endtask

    // Monitor: every cycle rd_valid must match whether the queue head is due now.
    initial begin
        logic exp_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            exp_v = (q.size() != 0) && (q[0].due == cyc);
            chk("rd_valid", rd_valid, exp_v);
            if (exp_v) begin
                chk("data_out", data_out, q[0].data);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset data_out", data_out, 16'h0000);
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset busy", busy, 4'b0000);
        chk("reset stall", stall, 1'b0);
        chk("reset err", err, 1'b0);
        rst_n = 1'b1;

        // Write then read the same word; bank 0 busy for three cycles after the read.
        drive(0, 1, 16'h0000, 16'h1111, 0, 0, 16'h0, 0);
        idle_busy(3, 4'b0001);
        drive(1, 0, 16'h0000, 16'h0, 0, 0, 16'h1111, 1);
        idle_busy(3, 4'b0001);
        idle_busy(1, 4'b0000);

        // Preload one word in each bank, then read them back-to-back across banks.
        drive(0, 1, 16'h0100, 16'hAAAA, 0, 0, 16'h0, 0);
        drive(0, 1, 16'h0102, 16'hBBBB, 0, 0, 16'h0, 0);
        drive(0, 1, 16'h0104, 16'hCCCC, 0, 0, 16'h0, 0);
        drive(0, 1, 16'h0106, 16'hDDDD, 0, 0, 16'h0, 0);
        idle(3);
        drive(1, 0, 16'h0100, 16'h0, 0, 0, 16'hAAAA, 1);
        drive(1, 0, 16'h0102, 16'h0, 0, 0, 16'hBBBB, 1);
        drive(1, 0, 16'h0104, 16'h0, 0, 0, 16'hCCCC, 1);
        drive(1, 0, 16'h0106, 16'h0, 0, 0, 16'hDDDD, 1);
        idle(4);

        // Same-bank read while busy stalls three times, then is accepted.
        drive(0, 1, 16'h0200, 16'h2222, 0, 0, 16'h0, 0);
        idle(3);
        drive(0, 1, 16'h0208, 16'h3333, 0, 0, 16'h0, 0);
        idle(3);
        drive(1, 0, 16'h0200, 16'h0, 0, 0, 16'h2222, 1);
        drive(1, 0, 16'h0208, 16'h0, 0, 1, 16'h0, 1);
        drive(1, 0, 16'h0208, 16'h0, 0, 1, 16'h0, 1);
        drive(1, 0, 16'h0208, 16'h0, 0, 1, 16'h0, 1);
        drive(1, 0, 16'h0208, 16'h0, 0, 0, 16'h3333, 1);
        idle(4);

        // Illegal requests: odd address, rd&wr together, and rd&wr to a busy bank.
        drive(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0, 1);
        idle_busy(1, 4'b0000);
        drive(1, 1, 16'h0004, 16'h5555, 1, 0, 16'h0, 1);
        idle_busy(1, 4'b0000);
        drive(1, 0, 16'h0000, 16'h0, 0, 0, 16'h1111, 1);
        drive(1, 1, 16'h0000, 16'h9999, 1, 0, 16'h0, 1);
        idle_busy(2, 4'b0001);
        idle_busy(1, 4'b0000);

        // Write then read-after-write to the same word: early retry stalls.
        drive(0, 1, 16'h0006, 16'hBEEF, 0, 0, 16'h0, 0);
        idle(2);
        drive(1, 0, 16'h0006, 16'h0, 0, 1, 16'h0, 1);
        drive(1, 0, 16'h0006, 16'h0, 0, 0, 16'hBEEF, 1);
        idle(4);

        // Reset one cycle after a read: it is never reported and busy clears at once.
        drive(1, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk);
        rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("busy in reset", busy, 4'b0000);
        chk("rd_valid in reset", rd_valid, 1'b0);
        idle(2);
        rst_n = 1'b1;
        drive(1, 0, 16'h0006, 16'h0, 0, 0, 16'hBEEF, 1);
        drive(1, 0, 16'h0100, 16'h0, 0, 0, 16'hAAAA, 1);
        idle(6);
        chk("queue drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
